// File: rtl/sipo_deserializer_pkg.sv
// sipo_deserializer_pkg: bit-order constants and counter-width helper shared by the deserializer
package sipo_deserializer_pkg;

   localparam int BIT_ORDER_MSB = 1;
   localparam int BIT_ORDER_LSB = 0;

   function automatic int cnt_width(input int width);
      int w;
      w = 0;
      while ((1 << w) < width) w++;
      return w;
   endfunction

endpackage

// File: rtl/sipo_deserializer.sv
// sipo_deserializer: collects WIDTH serial bits into a word held on a valid/ready output
module sipo_deserializer
   import sipo_deserializer_pkg::*;
#(
   parameter  int WIDTH     = 8,
   parameter  int MSB_FIRST = BIT_ORDER_MSB,
   localparam int CNT_W     = cnt_width(WIDTH)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             serial_in,
   input  logic             serial_valid,
   input  logic             frame_start,
   output logic [WIDTH-1:0] par_data,
   output logic             par_valid,
   input  logic             par_ready,
   output logic             overrun,
   output logic [CNT_W-1:0] bit_count
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   logic [WIDTH-1:0] r_shreg;
   logic [WIDTH-1:0] r_par_data;
   logic             r_par_valid;
   logic             r_overrun;
   logic [CNT_W-1:0] r_count;

   logic [WIDTH-1:0] w_shifted;
   logic [WIDTH-1:0] w_first;
   logic             w_complete;
   logic             w_load;

   always_comb begin
      w_shifted  = (MSB_FIRST == BIT_ORDER_MSB) ? {r_shreg[WIDTH-2:0], serial_in}
                                                 : {serial_in, r_shreg[WIDTH-1:1]};
      // a frame start restarts the word with stale bits zeroed
      w_first    = (MSB_FIRST == BIT_ORDER_MSB) ? {{(WIDTH-1){1'b0}}, serial_in}
                                                 : {serial_in, {(WIDTH-1){1'b0}}};
      w_complete = serial_valid && !frame_start && (r_count == LAST);
      w_load     = w_complete && (!r_par_valid || par_ready);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_shreg <= '0;
         r_count <= '0;
      end else if (clear) begin
         r_shreg <= '0;
         r_count <= '0;
      end else if (serial_valid) begin
         r_shreg <= frame_start ? w_first : w_shifted;
         r_count <= frame_start ? CNT_W'(1) : (w_complete ? '0 : r_count + 1'b1);
      end
   end

   // a word completing while the previous one is still unconsumed is dropped
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_par_data  <= '0;
         r_par_valid <= 1'b0;
         r_overrun   <= 1'b0;
      end else if (clear) begin
         r_par_data  <= '0;
         r_par_valid <= 1'b0;
         r_overrun   <= 1'b0;
      end else if (w_load) begin
         r_par_data  <= w_shifted;
         r_par_valid <= 1'b1;
      end else begin
         if (par_ready) r_par_valid <= 1'b0;
         if (w_complete) r_overrun <= 1'b1;
      end
   end

   assign par_data  = r_par_data;
   assign par_valid = r_par_valid;
   assign overrun   = r_overrun;
   assign bit_count = r_count;

endmodule
